// File: rtl/ines_loader.sv
// iNES image loader: takes bytes from the UART, checks the 16-byte header and
// streams one PRG bank and one CHR bank into the ROM write ports.
module ines_loader #(
    parameter int PRG_LEN = 16384,
    parameter int CHR_LEN = 8192,
    parameter int TIMEOUT = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_ready,
    output logic [7:0]  wdata,
    output logic [13:0] prg_addr,
    output logic        prg_we,
    output logic [12:0] chr_addr,
    output logic        chr_we,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);

    localparam int                TCNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [14:0]       PRG_LAST = 15'(PRG_LEN - 1);
    localparam logic [14:0]       CHR_LAST = 15'(CHR_LEN - 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_MAGIC   = 2'd1;
    localparam logic [1:0] ERR_BANKS   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PRG,
        ST_CHR,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          sync_q;
    logic [14:0]         bcnt_q, bcnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [13:0]         prg_addr_q, prg_addr_d;
    logic [12:0]         chr_addr_q, chr_addr_d;
    logic                prg_we_q, prg_we_d;
    logic                chr_we_q, chr_we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [1:0]          err_q, err_d;

    logic bev;
    logic active;
    logic timeout;
    logic hdr_bad_magic;
    logic hdr_bad_bank;

    // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the edge-detect delay
    assign bev     = sync_q[1] & ~sync_q[2];
    assign active  = (state_q == ST_HDR) || (state_q == ST_PRG) || (state_q == ST_CHR);
    assign timeout = active && !bev && (tcnt_q >= TCNT_MAX);

    always_comb begin
        hdr_bad_magic = 1'b0;
        hdr_bad_bank  = 1'b0;
        case (bcnt_q)
            15'd1:        hdr_bad_magic = (rx_byte != 8'h45);
            15'd2:        hdr_bad_magic = (rx_byte != 8'h53);
            15'd3:        hdr_bad_magic = (rx_byte != 8'h1A);
            15'd4, 15'd5: hdr_bad_bank  = (rx_byte != 8'h01);
            default:      ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        wdata_d    = wdata_q;
        prg_addr_d = prg_addr_q;
        chr_addr_d = chr_addr_q;
        prg_we_d   = 1'b0;
        chr_we_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;

        // rx_byte is stable while rx_ready is high, so capture it directly on bev
        if (bev) begin
            wdata_d = rx_byte;
        end

        if (bev || !active) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
        end

        if (timeout) begin
            err_d   = ERR_TIMEOUT;
            busy_d  = 1'b0;
            state_d = ST_ERR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bev && rx_byte == 8'h4E) begin
                        state_d = ST_HDR;
                        bcnt_d  = 15'd1;
                        busy_d  = 1'b1;
                        err_d   = ERR_NONE;
                    end
                end
                ST_HDR: begin
                    if (bev) begin
                        if (hdr_bad_magic) begin
                            err_d   = ERR_MAGIC;
                            busy_d  = 1'b0;
                            state_d = ST_ERR;
                        end else if (hdr_bad_bank) begin
                            err_d   = ERR_BANKS;
                            busy_d  = 1'b0;
                            state_d = ST_ERR;
                        end else if (bcnt_q == 15'd15) begin
                            bcnt_d  = '0;
                            state_d = ST_PRG;
                        end else begin
                            bcnt_d = bcnt_q + 15'd1;
                        end
                    end
                end
                ST_PRG: begin
                    if (bev) begin
                        prg_we_d   = 1'b1;
                        prg_addr_d = bcnt_q[13:0];
                        if (bcnt_q == PRG_LAST) begin
                            bcnt_d  = '0;
                            state_d = ST_CHR;
                        end else begin
                            bcnt_d = bcnt_q + 15'd1;
                        end
                    end
                end
                ST_CHR: begin
                    if (bev) begin
                        chr_we_d   = 1'b1;
                        chr_addr_d = bcnt_q[12:0];
                        if (bcnt_q == CHR_LAST) begin
                            bcnt_d  = '0;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_DONE;
                        end else begin
                            bcnt_d = bcnt_q + 15'd1;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                ST_ERR:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sync_q     <= '0;
            bcnt_q     <= '0;
            tcnt_q     <= '0;
            wdata_q    <= '0;
            prg_addr_q <= '0;
            chr_addr_q <= '0;
            prg_we_q   <= 1'b0;
            chr_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[1:0], rx_ready};
            bcnt_q     <= bcnt_d;
            tcnt_q     <= tcnt_d;
            wdata_q    <= wdata_d;
            prg_addr_q <= prg_addr_d;
            chr_addr_q <= chr_addr_d;
            prg_we_q   <= prg_we_d;
            chr_we_q   <= chr_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign wdata    = wdata_q;
    assign prg_addr = prg_addr_q;
    assign prg_we   = prg_we_q;
    assign chr_addr = chr_addr_q;
    assign chr_we   = chr_we_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ines_loader.sv
// Directed bench for ines_loader using reduced bank sizes and a short timeout
// so every load scenario runs in a few thousand cycles.
module tb_ines_loader;

    localparam int PRG_LEN = 256;
    localparam int CHR_LEN = 128;
    localparam int TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic [7:0]  wdata;
    logic [13:0] prg_addr;
    logic        prg_we;
    logic [12:0] chr_addr;
    logic        chr_we;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    int         prg_cnt, chr_cnt, prg_bad, chr_bad, both_we, done_cnt;
    logic [7:0] prg_at34;
    logic       mon_clear = 1'b0;

    ines_loader #(
        .PRG_LEN(PRG_LEN),
        .CHR_LEN(CHR_LEN),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_byte  (rx_byte),
        .rx_ready (rx_ready),
        .wdata    (wdata),
        .prg_addr (prg_addr),
        .prg_we   (prg_we),
        .chr_addr (chr_addr),
        .chr_we   (chr_we),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Write monitor: the n-th PRG write must hit address n with data n&FF,
    // the n-th CHR write address n with data ~n&FF.
    always @(negedge clk) begin
        if (mon_clear) begin
            prg_cnt  = 0;
            chr_cnt  = 0;
            prg_bad  = 0;
            chr_bad  = 0;
            both_we  = 0;
            done_cnt = 0;
            prg_at34 = 8'h00;
        end else begin
            if (prg_we) begin
                if (prg_addr != prg_cnt[13:0] || wdata != prg_cnt[7:0]) prg_bad++;
                if (prg_addr == 14'h0034) prg_at34 = wdata;
                prg_cnt++;
            end
            if (chr_we) begin
                if (chr_addr != chr_cnt[12:0] || wdata != ~chr_cnt[7:0]) chr_bad++;
                chr_cnt++;
            end
            if (prg_we && chr_we) both_we++;
            if (done) done_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rx_byte  = b;
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        rx_ready = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic clearMonitor();
        mon_clear = 1'b1;
        @(negedge clk);
        @(posedge clk);
        mon_clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic sendHeader(input logic [7:0] prg_count);
        applyStimulus(8'h4E);
        applyStimulus(8'h45);
        applyStimulus(8'h53);
        applyStimulus(8'h1A);
        applyStimulus(prg_count);
        applyStimulus(8'h01);
        for (int i = 0; i < 10; i++) applyStimulus(8'h00);
    endtask

    task automatic sendPrg(input int n);
        for (int i = 0; i < n; i++) applyStimulus(8'(i));
    endtask

    task automatic sendChr(input int n);
        for (int i = 0; i < n; i++) applyStimulus(~8'(i));
    endtask

    task automatic checkFullLoad(input string tag);
        checkOutput({tag, "_prg_count"}, prg_cnt, PRG_LEN);
        checkOutput({tag, "_prg_seq"}, prg_bad, 0);
        checkOutput({tag, "_chr_count"}, chr_cnt, CHR_LEN);
        checkOutput({tag, "_chr_seq"}, chr_bad, 0);
        checkOutput({tag, "_done_pulses"}, done_cnt, 1);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_both_we"}, both_we, 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wait_cycles;
        reset    = 1'b1;
        rx_byte  = 8'h00;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clearMonitor();

        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_prg_we", prg_we, 0);
        checkOutput("rst_chr_we", chr_we, 0);
        checkOutput("rst_prg_addr", prg_addr, 0);

        $display("[TB] valid image");
        applyStimulus(8'h4E);
        checkOutput("valid_busy_first_byte", busy, 1);
        applyStimulus(8'h45);
        applyStimulus(8'h53);
        applyStimulus(8'h1A);
        applyStimulus(8'h01);
        applyStimulus(8'h01);
        for (int i = 0; i < 10; i++) applyStimulus(8'h00);
        sendPrg(PRG_LEN);
        checkOutput("valid_busy_mid", busy, 1);
        sendChr(CHR_LEN);
        repeat (4) @(negedge clk);
        checkFullLoad("valid");
        checkOutput("valid_data_at_34", prg_at34, 8'h34);

        $display("[TB] bad magic then valid image");
        clearMonitor();
        applyStimulus(8'h4E);
        applyStimulus(8'h45);
        applyStimulus(8'h58);
        checkOutput("magic_err", err, 1);
        checkOutput("magic_busy", busy, 0);
        checkOutput("magic_writes", prg_cnt + chr_cnt, 0);
        sendHeader(8'h01);
        checkOutput("magic_err_cleared", err, 0);
        sendPrg(PRG_LEN);
        sendChr(CHR_LEN);
        repeat (4) @(negedge clk);
        checkFullLoad("after_magic");

        $display("[TB] bad PRG bank count");
        clearMonitor();
        applyStimulus(8'h4E);
        applyStimulus(8'h45);
        applyStimulus(8'h53);
        applyStimulus(8'h1A);
        checkOutput("banks_err_before", err, 0);
        checkOutput("banks_busy_before", busy, 1);
        applyStimulus(8'h02);
        checkOutput("banks_err", err, 2);
        checkOutput("banks_busy", busy, 0);
        checkOutput("banks_writes", prg_cnt + chr_cnt, 0);

        $display("[TB] timeout after PRG byte 100");
        clearMonitor();
        sendHeader(8'h01);
        sendPrg(100);
        repeat (800) @(negedge clk);
        checkOutput("tmo_err_early", err, 0);
        checkOutput("tmo_busy_early", busy, 1);
        wait_cycles = 0;
        while (err != 2'd3 && wait_cycles < 400) begin
            @(negedge clk);
            wait_cycles++;
        end
        checkOutput("tmo_err", err, 3);
        checkOutput("tmo_busy", busy, 0);
        checkOutput("tmo_prg_writes", prg_cnt, 100);
        checkOutput("tmo_prg_seq", prg_bad, 0);
        checkOutput("tmo_chr_writes", chr_cnt, 0);

        $display("[TB] garbage then valid image");
        clearMonitor();
        applyStimulus(8'hFF);
        applyStimulus(8'h00);
        applyStimulus(8'h4D);
        checkOutput("garbage_busy", busy, 0);
        checkOutput("garbage_err_held", err, 3);
        sendHeader(8'h01);
        sendPrg(PRG_LEN);
        sendChr(CHR_LEN);
        repeat (4) @(negedge clk);
        checkFullLoad("garbage");

        $display("[TB] reset during CHR");
        clearMonitor();
        sendHeader(8'h01);
        sendPrg(PRG_LEN);
        sendChr(51);
        checkOutput("rstmid_chr_before", chr_cnt, 51);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rstmid_busy", busy, 0);
        checkOutput("rstmid_chr_we", chr_we, 0);
        checkOutput("rstmid_err", err, 0);
        repeat (20) @(negedge clk);
        checkOutput("rstmid_chr_after", chr_cnt, 51);
        clearMonitor();
        sendHeader(8'h01);
        sendPrg(PRG_LEN);
        sendChr(CHR_LEN);
        repeat (4) @(negedge clk);
        checkFullLoad("reload");
        checkOutput("reload_data_at_34", prg_at34, 8'h34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
